ram_byte_store: RTL and testbench

- Byte-wide line-burst RAM slave on the ram_clk side of the cache-to-RAM bridge, directly downstream of the cache/RAM interface.
- Accepts line write bursts and line read requests over the addr_r/rnw/wdata_r/aval bus.
- Returns read bytes on rdata_r with one rack strobe per byte.
- Returns a single rack strobe when a write burst completes.

---
 rtl/ram_byte_store.sv | 168 ++++++++++++++++
 tb/tb_ram_byte_store.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ram_byte_store.sv
// Byte-wide line-burst RAM slave: write bursts ack'd with one rack pulse, read bursts return one byte per rack.
// Optional sticky protocol checker built when RAM_STORE_PROTO_CHECK_EN is defined.
module ram_byte_store #(
    parameter int ADDR_W    = 13,
    parameter int LINE_W    = 8,
    parameter int BURST_LEN = 8,
    parameter int READ_LAT  = 3,
    parameter int WRITE_LAT = 2
) (
    input  logic              ram_clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_r,
    input  logic              rnw,
    input  logic [7:0]        wdata_r,
    input  logic              aval,
    output logic [7:0]        rdata_r,
    output logic              rack,
    output logic              busy,
    output logic              proto_err
);

    // Handshake: aval marks beat 0 and is honoured only in IDLE; writes stream one byte per
    // cycle with no gaps, reads return BURST_LEN bytes on consecutive cycles with rack=1.
    localparam int BEAT_W  = $clog2(BURST_LEN);
    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);
    localparam int DEPTH   = 2 ** (LINE_W + BEAT_W);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [LAT_W-1:0]  RD_LOAD   = LAT_W'(READ_LAT - 1);
    localparam logic [LAT_W-1:0]  WR_LOAD   = LAT_W'(WRITE_LAT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_LAT  = 3'd2,
        RD_LAT  = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    state_t                   state, state_d;
    logic [BEAT_W-1:0]        beat, beat_d;
    logic [LAT_W-1:0]         lat, lat_d;
    logic [LINE_W-1:0]        line, line_d;
    logic                     mem_we;
    logic [LINE_W+BEAT_W-1:0] mem_waddr;
    logic [LINE_W+BEAT_W-1:0] mem_raddr;
    logic                     rack_d;
    logic [7:0]               rdata_d;
    logic [7:0]               mem [DEPTH];

    generate
        if (ADDR_W > LINE_W) begin : g_alias
            logic addr_hi_unused;
            assign addr_hi_unused = ^addr_r[ADDR_W-1:LINE_W];
        end
    endgenerate

    always_comb begin
        state_d   = state;
        beat_d    = beat;
        lat_d     = lat;
        line_d    = line;
        mem_we    = 1'b0;
        mem_waddr = {line, beat};
        case (state)
            IDLE: begin
                if (aval) begin
                    line_d = addr_r[LINE_W-1:0];
                    if (rnw) begin
                        beat_d = '0;
                        if (READ_LAT == 1) begin
                            state_d = RD_DATA;
                            lat_d   = '0;
                        end else begin
                            state_d = RD_LAT;
                            lat_d   = RD_LOAD;
                        end
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = {addr_r[LINE_W-1:0], BEAT_W'(0)};
                        beat_d    = BEAT_W'(1);
                        state_d   = WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                mem_we = 1'b1;
                if (beat == LAST_BEAT) begin
                    state_d = WR_LAT;
                    lat_d   = WR_LOAD;
                    beat_d  = '0;
                end else begin
                    beat_d = beat + BEAT_W'(1);
                end
            end
            WR_LAT: begin
                if (lat == '0) begin
                    state_d = IDLE;
                end else begin
                    lat_d = lat - LAT_W'(1);
                end
            end
            RD_LAT: begin
                // Count reaches 0 on the edge into RD_DATA so byte 0 lands READ_LAT cycles after the request.
                lat_d = lat - LAT_W'(1);
                if (lat == LAT_W'(1)) begin
                    state_d = RD_DATA;
                    beat_d  = '0;
                end
            end
            RD_DATA: begin
                if (beat == LAST_BEAT) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered: look ahead at the next state to fill rack/rdata_r.
        mem_raddr = {line_d, beat_d};
        rack_d    = (state_d == RD_DATA) || ((state_d == WR_LAT) && (lat_d == '0));
        rdata_d   = (state_d == RD_DATA) ? mem[mem_raddr] : rdata_r;
    end

    always_ff @(posedge ram_clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            beat    <= '0;
            lat     <= '0;
            line    <= '0;
            rack    <= 1'b0;
            rdata_r <= 8'h00;
        end else begin
            state   <= state_d;
            beat    <= beat_d;
            lat     <= lat_d;
            line    <= line_d;
            rack    <= rack_d;
            rdata_r <= rdata_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge ram_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= wdata_r;
        end
    end

    assign busy = (state != IDLE);

`ifdef RAM_STORE_PROTO_CHECK_EN
    always_ff @(posedge ram_clk or posedge reset) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (aval && busy) begin
            proto_err <= 1'b1;
        end
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_byte_store.sv
// Directed bench for ram_byte_store: table of line writes/reads plus hand-written corner sequences.
module tb_ram_byte_store;

  localparam int RL = 3;
  localparam int WL = 2;

  logic        clk;
  logic        reset;
  logic [12:0] addr_r;
  logic        rnw;
  logic [7:0]  wdata_r;
  logic        aval;
  logic [7:0]  rdata_r;
  logic        rack;
  logic        busy;
  logic        proto_err;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [7:0] last_rd;

  typedef struct {
    bit          is_rd;
    logic [12:0] addr;
    logic [63:0] data;
  } vec_t;

  vec_t vecs[8];

  ram_byte_store #(
    .ADDR_W(13), .LINE_W(8), .BURST_LEN(8), .READ_LAT(RL), .WRITE_LAT(WL)
  ) dut (
    .ram_clk(clk), .reset(reset), .addr_r(addr_r), .rnw(rnw), .wdata_r(wdata_r),
    .aval(aval), .rdata_r(rdata_r), .rack(rack), .busy(busy), .proto_err(proto_err)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [12:0] a, input logic [63:0] d, input string tag);
    aval = 1'b1; rnw = 1'b0; addr_r = a; wdata_r = d[63:56];
    check({tag, " idle busy"}, busy, 0);
    next_cyc;
    aval = 1'b0; rnw = 1'($urandom_range(0, 1)); addr_r = 13'($urandom);
    for (int b = 1; b < 8; b++) begin
      wdata_r = d[63-8*b -: 8];
      check($sformatf("%s beat%0d rack", tag, b), rack, 0);
      check($sformatf("%s beat%0d busy", tag, b), busy, 1);
      next_cyc;
    end
    wdata_r = 8'($urandom);
    for (int k = 1; k < WL; k++) begin
      check($sformatf("%s lat%0d rack", tag, k), rack, 0);
      next_cyc;
    end
    check({tag, " wr rack"}, rack, 1);
    check({tag, " rdata hold"}, rdata_r, last_rd);
    next_cyc;
    check({tag, " rack drop"}, rack, 0);
    check({tag, " busy drop"}, busy, 0);
  endtask

  task automatic do_read(input logic [12:0] a, input logic [63:0] exp, input int poke, input string tag);
    aval = 1'b1; rnw = 1'b1; addr_r = a;
    check({tag, " idle busy"}, busy, 0);
    next_cyc;
    aval = 1'b0; rnw = 1'($urandom_range(0, 1)); addr_r = 13'($urandom); wdata_r = 8'($urandom);
    for (int k = 1; k < RL; k++) begin
      check($sformatf("%s lat%0d rack", tag, k), rack, 0);
      check($sformatf("%s lat%0d busy", tag, k), busy, 1);
      next_cyc;
    end
    for (int b = 0; b < 8; b++) begin
      if (b == poke) begin
        aval = 1'b1; rnw = 1'b0; addr_r = 13'h0AA;
      end
      check($sformatf("%s b%0d rack", tag, b), rack, 1);
      check($sformatf("%s b%0d rdata", tag, b), rdata_r, exp[63-8*b -: 8]);
      next_cyc;
      aval = 1'b0;
    end
    check({tag, " rack drop"}, rack, 0);
    check({tag, " busy drop"}, busy, 0);
    check({tag, " rdata hold"}, rdata_r, exp[7:0]);
    last_rd = exp[7:0];
  endtask

  logic exp_perr;

  initial begin
    vecs[0] = '{1'b0, 13'h005, 64'h1122334455667788};
    vecs[1] = '{1'b1, 13'h005, 64'h1122334455667788};
    vecs[2] = '{1'b0, 13'h105, 64'hA0A1A2A3A4A5A6A7};
    vecs[3] = '{1'b1, 13'h005, 64'hA0A1A2A3A4A5A6A7};
    vecs[4] = '{1'b0, 13'h0FF, 64'hDEADBEEF01234567};
    vecs[5] = '{1'b1, 13'h1FF, 64'hDEADBEEF01234567};
    vecs[6] = '{1'b0, 13'h010, 64'h0F1E2D3C4B5A6978};
    vecs[7] = '{1'b1, 13'h010, 64'h0F1E2D3C4B5A6978};

`ifdef RAM_STORE_PROTO_CHECK_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif

    // reset
    reset = 1'b1; aval = 1'b0; rnw = 1'b0; addr_r = '0; wdata_r = '0; last_rd = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset rack", rack, 0);
    check("reset rdata", rdata_r, 8'h00);
    check("reset busy", busy, 0);
    check("reset proto_err", proto_err, 0);
    reset = 1'b0;
    next_cyc;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_rd) do_read(vecs[i].addr, vecs[i].data, -1, $sformatf("v%0d rd", i));
      else               do_write(vecs[i].addr, vecs[i].data, $sformatf("v%0d wr", i));
    end
    check("clean proto_err", proto_err, 0);

    // aval during RD_DATA is ignored by the burst
    do_read(13'h005, 64'hA0A1A2A3A4A5A6A7, 3, "poke rd");
    check("poke proto_err", proto_err, exp_perr);
    next_cyc;
    do_read(13'h0FF, 64'hDEADBEEF01234567, -1, "after poke rd");
    check("sticky proto_err", proto_err, exp_perr);

    // reset at write beat 4 of line 0x010
    aval = 1'b1; rnw = 1'b0; addr_r = 13'h010; wdata_r = 8'hC0;
    next_cyc;
    aval = 1'b0;
    for (int b = 1; b < 4; b++) begin
      wdata_r = 8'hC0 + 8'(b);
      next_cyc;
    end
    wdata_r = 8'hC4;
    reset = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst rack", rack, 0);
    check("midrst rdata", rdata_r, 8'h00);
    check("midrst proto_err", proto_err, 0);
    next_cyc;
    reset = 1'b0; last_rd = 8'h00;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("midrst no rack c%0d", k), rack, 0);
      check($sformatf("midrst idle c%0d", k), busy, 0);
      next_cyc;
    end
    do_read(13'h010, 64'hC0C1C2C34B5A6978, -1, "midrst rd");

    // back-to-back reads on the first IDLE cycle
    do_read(13'h005, 64'hA0A1A2A3A4A5A6A7, -1, "b2b rd0");
    do_read(13'h0FF, 64'hDEADBEEF01234567, -1, "b2b rd1");
    do_write(13'h033, 64'h0102030405060708, "b2b wr");
    do_read(13'h133, 64'h0102030405060708, -1, "b2b rd2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
